// File: rtl/nes_interrupt_unit.sv
// nes_interrupt_unit: 6502-style interrupt / RTI sequencer for the NES CPU core.
// After each instruction the engine pulses start. The unit either echoes the
// engine's PC/P/SP, or takes the memory bus to push a frame and fetch a vector
// (soft reset, NMI, BRK, IRQ) or to pull a frame (RTI).
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for start; selects the action by priority
// S_FINISH   | raise done, release the bus
// S_PUSH_HI  | write PC[15:8] to the stack
// S_PUSH_LO  | write PC[7:0] to the stack
// S_PUSH_P   | write P (bit5 set, bit4 = BRK) and mask further IRQs
// S_VEC_LO   | read vector low byte (3-cycle read)
// S_VEC_HI   | read vector high byte (3-cycle read)
// S_PULL_P   | RTI: pull P
// S_PULL_LO  | RTI: pull PCL
// S_PULL_HI  | RTI: pull PCH
module nes_interrupt_unit #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        write_en,
  input  logic        is_break,
  input  logic [7:0]  ppu_status,
  input  logic        soft_reset,
  input  logic        is_rti,
  input  logic        start,
  output logic        done,
  output logic        busy,
  input  logic [15:0] pc_in,
  input  logic [7:0]  status_in,
  input  logic [7:0]  stack_in,
  output logic [15:0] pc_out,
  output logic [7:0]  status_out,
  output logic [7:0]  stack_out,
  output logic        interrupt_disable,
  input  logic        halt,
  input  logic        nIRQ,
  input  logic [7:0]  ppu_ctrl1
);

  typedef enum logic [3:0] {
    S_IDLE, S_FINISH, S_PUSH_HI, S_PUSH_LO, S_PUSH_P,
    S_VEC_LO, S_VEC_HI, S_PULL_P, S_PULL_LO, S_PULL_HI
  } state_t;

  state_t      state, state_next;
  logic [1:0]  phase, phase_next;
  logic [15:0] vec, vec_next;
  logic        brk, brk_next;
  logic        nmi_pend, nmi_pend_next;
  logic        rst_pend, rst_pend_next;
  logic        n_prev;
  logic        nmi_take, rst_take;
  logic        nmi_level;
  logic [15:0] addr_next, pc_next, rd_addr;
  logic [7:0]  data_out_next, status_next, stack_next;
  logic        write_en_next, busy_next, done_next;

  assign nmi_level         = ppu_status[7] & ppu_ctrl1[7];
  assign interrupt_disable = status_out[2];

  // Address for the current read step: vector bytes or the next stack slot.
  always_comb begin
    rd_addr = vec;
    case (state)
      S_VEC_HI:                      rd_addr = vec + 16'd1;
      S_PULL_P, S_PULL_LO, S_PULL_HI: rd_addr = {8'h01, stack_out + 8'd1};
      default:                       rd_addr = vec;
    endcase
  end

  // Next-state and datapath decode; halt freezes everything but event latching.
  always_comb begin
    state_next    = state;
    phase_next    = phase;
    vec_next      = vec;
    brk_next      = brk;
    addr_next     = addr;
    data_out_next = data_out;
    write_en_next = 1'b0;
    busy_next     = busy;
    done_next     = done;
    pc_next       = pc_out;
    status_next   = status_out;
    stack_next    = stack_out;
    nmi_take      = 1'b0;
    rst_take      = 1'b0;

    if (!halt) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc_next     = pc_in;
            status_next = status_in;
            stack_next  = stack_in;
            done_next   = 1'b0;
            phase_next  = 2'd0;
            brk_next    = 1'b0;
            if (rst_pend) begin
              rst_take    = 1'b1;
              stack_next  = stack_in - 8'd3;
              status_next = status_in | 8'h04;
              vec_next    = RST_VEC;
              busy_next   = 1'b1;
              state_next  = S_VEC_LO;
            end else if (is_rti) begin
              busy_next  = 1'b1;
              state_next = S_PULL_P;
            end else if (nmi_pend) begin
              nmi_take   = 1'b1;
              vec_next   = NMI_VEC;
              busy_next  = 1'b1;
              state_next = S_PUSH_HI;
            end else if (is_break) begin
              brk_next   = 1'b1;
              vec_next   = IRQ_VEC;
              busy_next  = 1'b1;
              state_next = S_PUSH_HI;
            end else if (!nIRQ && !status_in[2]) begin
              vec_next   = IRQ_VEC;
              busy_next  = 1'b1;
              state_next = S_PUSH_HI;
            end else begin
              state_next = S_FINISH;
            end
          end
        end
        S_FINISH: begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end
        S_PUSH_HI, S_PUSH_LO, S_PUSH_P: begin
          addr_next     = {8'h01, stack_out};
          write_en_next = 1'b1;
          stack_next    = stack_out - 8'd1;
          if (state == S_PUSH_HI) begin
            data_out_next = pc_out[15:8];
            state_next    = S_PUSH_LO;
          end else if (state == S_PUSH_LO) begin
            data_out_next = pc_out[7:0];
            state_next    = S_PUSH_P;
          end else begin
            // Pushed copy carries B only for BRK; live P gets I set, B/bit5 cleared.
            data_out_next = (status_out & 8'hEF) | 8'h20 | {3'b000, brk, 4'b0000};
            status_next   = (status_out | 8'h04) & 8'hCF;
            phase_next    = 2'd0;
            state_next    = S_VEC_LO;
          end
        end
        S_VEC_LO, S_VEC_HI, S_PULL_P, S_PULL_LO, S_PULL_HI: begin
          if (phase == 2'd0) begin
            addr_next  = rd_addr;
            phase_next = 2'd1;
            if (state == S_PULL_P || state == S_PULL_LO || state == S_PULL_HI)
              stack_next = stack_out + 8'd1;
          end else if (phase == 2'd1) begin
            phase_next = 2'd2;
          end else begin
            phase_next = 2'd0;
            case (state)
              S_VEC_LO: begin
                pc_next[7:0] = data_in;
                state_next   = S_VEC_HI;
              end
              S_VEC_HI: begin
                pc_next[15:8] = data_in;
                state_next    = S_FINISH;
              end
              S_PULL_P: begin
                status_next = data_in & 8'hCF;
                state_next  = S_PULL_LO;
              end
              S_PULL_LO: begin
                pc_next[7:0] = data_in;
                state_next   = S_PULL_HI;
              end
              default: begin
                pc_next[15:8] = data_in;
                state_next    = S_FINISH;
              end
            endcase
          end
        end
        default: state_next = S_IDLE;
      endcase
    end

    // A new event arriving in the same cycle as a service keeps the flag set.
    nmi_pend_next = (nmi_pend & ~nmi_take) | (nmi_level & ~n_prev);
    rst_pend_next = (rst_pend & ~rst_take) | soft_reset;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      phase      <= 2'd0;
      vec        <= 16'h0000;
      brk        <= 1'b0;
      nmi_pend   <= 1'b0;
      rst_pend   <= 1'b0;
      n_prev     <= 1'b0;
      addr       <= 16'h0000;
      data_out   <= 8'h00;
      write_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pc_out     <= 16'h0000;
      status_out <= 8'h00;
      stack_out  <= 8'hFF;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      vec        <= vec_next;
      brk        <= brk_next;
      nmi_pend   <= nmi_pend_next;
      rst_pend   <= rst_pend_next;
      n_prev     <= nmi_level;
      addr       <= addr_next;
      data_out   <= data_out_next;
      write_en   <= write_en_next;
      busy       <= busy_next;
      done       <= done_next;
      pc_out     <= pc_next;
      status_out <= status_next;
      stack_out  <= stack_next;
    end
  end

endmodule

// File: tb/tb_nes_interrupt_unit.sv
// Directed bench for nes_interrupt_unit with a byte-wide memory model.
module tb_nes_interrupt_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        write_en;
  logic        is_break = 1'b0;
  logic [7:0]  ppu_status = 8'h00;
  logic        soft_reset = 1'b0;
  logic        is_rti = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic        busy;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  status_in = 8'h00;
  logic [7:0]  stack_in = 8'h00;
  logic [15:0] pc_out;
  logic [7:0]  status_out;
  logic [7:0]  stack_out;
  logic        interrupt_disable;
  logic        halt = 1'b0;
  logic        nIRQ = 1'b1;
  logic [7:0]  ppu_ctrl1 = 8'h00;

  logic [7:0]  mem [0:65535];
  logic [23:0] wlog [0:63];
  int          wcnt = 0;
  int          bcnt = 0;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign data_in = mem[addr];

  nes_interrupt_unit dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
    .write_en(write_en), .is_break(is_break), .ppu_status(ppu_status),
    .soft_reset(soft_reset), .is_rti(is_rti), .start(start), .done(done),
    .busy(busy), .pc_in(pc_in), .status_in(status_in), .stack_in(stack_in),
    .pc_out(pc_out), .status_out(status_out), .stack_out(stack_out),
    .interrupt_disable(interrupt_disable), .halt(halt), .nIRQ(nIRQ),
    .ppu_ctrl1(ppu_ctrl1)
  );

  // Log every stack write and count busy cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_en && wcnt < 64) begin
      wlog[wcnt] <= {addr, data_out};
      wcnt <= wcnt + 1;
    end
    if (busy) bcnt <= bcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp);
    @(negedge clk);
    pc_in = pc; status_in = p; stack_in = sp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_frame(input string tag, input int base,
                           input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2);
    chk({tag, "_nwr"}, wcnt - base, 3);
    chk({tag, "_w0"}, {8'd0, wlog[base]}, {8'd0, w0});
    chk({tag, "_w1"}, {8'd0, wlog[base+1]}, {8'd0, w1});
    chk({tag, "_w2"}, {8'd0, wlog[base+2]}, {8'd0, w2});
  endtask

  initial begin
    int wb, bb;
    logic [15:0] held;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'h34; mem[16'hFFFB] = 8'h12;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'hFFFE] = 8'hCD; mem[16'hFFFF] = 8'hAB;
    mem[16'h01FB] = 8'hFF; mem[16'h01FC] = 8'h78; mem[16'h01FD] = 8'h56;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_addr", {16'd0, addr}, 32'h0);
    chk("rst_dout", {24'd0, data_out}, 32'h0);
    chk("rst_we", {31'd0, write_en}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    chk("rst_pc", {16'd0, pc_out}, 32'h0);
    chk("rst_p", {24'd0, status_out}, 32'h0);
    chk("rst_sp", {24'd0, stack_out}, 32'hFF);
    rst = 1'b1;

    // 1: no work, echo with one-cycle latency
    bb = bcnt; wb = wcnt;
    do_start(16'h8003, 8'h24, 8'hFD);
    chk("t1_done_early", {31'd0, done}, 32'h0);
    @(negedge clk);
    chk("t1_done", {31'd0, done}, 32'h1);
    chk("t1_pc", {16'd0, pc_out}, 32'h8003);
    chk("t1_p", {24'd0, status_out}, 32'h24);
    chk("t1_sp", {24'd0, stack_out}, 32'hFD);
    repeat (2) @(negedge clk);
    chk("t1_done_hold", {31'd0, done}, 32'h1);
    chk("t1_nobusy", bcnt - bb, 0);
    chk("t1_nowr", wcnt - wb, 0);

    // 2: NMI on vblank rising edge
    ppu_ctrl1 = 8'h80;
    @(negedge clk); ppu_status = 8'h80;
    @(negedge clk);
    wb = wcnt; bb = bcnt;
    do_start(16'hC123, 8'h00, 8'hFD);
    wait_done("t2_timeout");
    chk_frame("t2", wb, 24'h01FDC1, 24'h01FC23, 24'h01FB20);
    chk("t2_pc", {16'd0, pc_out}, 32'h1234);
    chk("t2_sp", {24'd0, stack_out}, 32'hFA);
    chk("t2_p", {24'd0, status_out}, 32'h04);
    chk("t2_busy_seen", {31'd0, (bcnt - bb) > 0}, 32'h1);
    wb = wcnt;
    do_start(16'hC123, 8'h00, 8'hFD);
    wait_done("t2b_timeout");
    chk("t2b_nowr", wcnt - wb, 0);
    chk("t2b_pc", {16'd0, pc_out}, 32'hC123);

    // 3: BRK pushes B set
    ppu_status = 8'h00;
    is_break = 1'b1;
    wb = wcnt;
    do_start(16'h9000, 8'h01, 8'hFD);
    wait_done("t3_timeout");
    is_break = 1'b0;
    chk_frame("t3", wb, 24'h01FD90, 24'h01FC00, 24'h01FB31);
    chk("t3_pc", {16'd0, pc_out}, 32'hABCD);
    chk("t3_p", {24'd0, status_out}, 32'h05);
    chk("t3_idis", {31'd0, interrupt_disable}, 32'h1);
    chk("t3_sp", {24'd0, stack_out}, 32'hFA);

    // 4: IRQ masked, then taken
    nIRQ = 1'b0;
    wb = wcnt;
    do_start(16'h6000, 8'h04, 8'hF0);
    wait_done("t4a_timeout");
    chk("t4a_nowr", wcnt - wb, 0);
    chk("t4a_pc", {16'd0, pc_out}, 32'h6000);
    wb = wcnt;
    do_start(16'h7000, 8'h00, 8'hF0);
    wait_done("t4b_timeout");
    nIRQ = 1'b1;
    chk_frame("t4b", wb, 24'h01F070, 24'h01EF00, 24'h01EE20);
    chk("t4b_pc", {16'd0, pc_out}, 32'hABCD);
    chk("t4b_sp", {24'd0, stack_out}, 32'hED);
    chk("t4b_p", {24'd0, status_out}, 32'h04);

    // 5: RTI
    is_rti = 1'b1;
    wb = wcnt;
    do_start(16'h1111, 8'h04, 8'hFA);
    wait_done("t5_timeout");
    is_rti = 1'b0;
    chk("t5_nowr", wcnt - wb, 0);
    chk("t5_p", {24'd0, status_out}, 32'hCF);
    chk("t5_pc", {16'd0, pc_out}, 32'h5678);
    chk("t5_sp", {24'd0, stack_out}, 32'hFD);

    // 6: soft reset with halt mid-read; NMI edge latched during halt
    @(negedge clk); soft_reset = 1'b1;
    @(negedge clk); soft_reset = 1'b0;
    wb = wcnt;
    do_start(16'h1234, 8'h00, 8'hFD);
    @(negedge clk);
    chk("t6_rd_addr", {16'd0, addr}, 32'hFFFC);
    held = addr;
    halt = 1'b1; ppu_status = 8'h80;
    repeat (5) @(negedge clk);
    chk("t6_halt_addr", {16'd0, addr}, {16'd0, held});
    chk("t6_halt_busy", {31'd0, busy}, 32'h1);
    chk("t6_halt_done", {31'd0, done}, 32'h0);
    chk("t6_halt_we", {31'd0, write_en}, 32'h0);
    halt = 1'b0;
    wait_done("t6_timeout");
    chk("t6_nowr", wcnt - wb, 0);
    chk("t6_pc", {16'd0, pc_out}, 32'h8000);
    chk("t6_sp", {24'd0, stack_out}, 32'hFA);
    chk("t6_p", {24'd0, status_out}, 32'h04);
    wb = wcnt;
    do_start(16'h4000, 8'h00, 8'hFA);
    wait_done("t6n_timeout");
    chk_frame("t6n", wb, 24'h01FA40, 24'h01F900, 24'h01F820);
    chk("t6n_pc", {16'd0, pc_out}, 32'h1234);

    // Reset in the middle of a BRK frame aborts it
    ppu_status = 8'h00;
    is_break = 1'b1;
    do_start(16'h9000, 8'h00, 8'hFD);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_we", {31'd0, write_en}, 32'h0);
    chk("abort_sp", {24'd0, stack_out}, 32'hFF);
    chk("abort_pc", {16'd0, pc_out}, 32'h0);
    is_break = 1'b0;
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
